// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch (IF) and load/store (LS).
// One outstanding transaction; LS has priority, with IF forced after LS_MAX consecutive LS grants.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned LS_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_req_ready,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_data,
   input  logic                ls_req_valid,
   input  logic                ls_req_we,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_wmask,
   output logic                ls_req_ready,
   output logic                ls_rsp_valid,
   output logic [DATA_W-1:0]   ls_rsp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_we,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rsp_data,
   output logic                busy,
   output logic                spurious_rsp
);

   localparam int unsigned MASK_W   = DATA_W / 8;
   localparam int unsigned STREAK_W = (LS_MAX < 1) ? 1 : $clog2(LS_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LS_MAX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_RSP
   } state_t;

   state_t                state;
   state_t                next_state;
   logic                  owner_ls;
   logic [STREAK_W-1:0]   ls_streak;
   logic                  grant_if_c;
   logic                  grant_ls_c;
   logic                  ls_wins_c;
   logic                  rsp_fire_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Grant and next-state; readies are combinational so acceptance happens in the IDLE cycle
   always_comb begin
      next_state = state;
      grant_if_c = 1'b0;
      grant_ls_c = 1'b0;
      rsp_fire_c = 1'b0;
      ls_wins_c  = ls_req_valid && !(if_req_valid && (ls_streak == STREAK_MAX));
      case (state)
         ST_IDLE: begin
            if (!rst) begin
               grant_ls_c = ls_wins_c;
               grant_if_c = if_req_valid && !ls_wins_c;
            end
            if (grant_ls_c || grant_if_c) next_state = ST_REQ;
         end
         ST_REQ: begin
            if (mem_req_ready) next_state = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (mem_rsp_valid) begin
               rsp_fire_c = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign if_req_ready = grant_if_c;
   assign ls_req_ready = grant_ls_c;

   // Request capture, response routing, streak tracking and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_ls      <= 1'b0;
         ls_streak     <= '0;
         mem_req_valid <= 1'b0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
         if_rsp_valid  <= 1'b0;
         if_rsp_data   <= '0;
         ls_rsp_valid  <= 1'b0;
         ls_rsp_data   <= '0;
         busy          <= 1'b0;
         spurious_rsp  <= 1'b0;
      end else begin
         mem_req_valid <= (next_state == ST_REQ);
         busy          <= (next_state != ST_IDLE);

         if (grant_ls_c) begin
            owner_ls      <= 1'b1;
            mem_req_we    <= ls_req_we;
            mem_req_addr  <= ls_req_addr;
            mem_req_wdata <= ls_req_wdata;
            mem_req_wmask <= ls_req_wmask;
         end else if (grant_if_c) begin
            owner_ls      <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= if_req_addr;
            mem_req_wdata <= '0;
            mem_req_wmask <= MASK_W'(0);
         end

         if_rsp_valid <= rsp_fire_c && !owner_ls;
         ls_rsp_valid <= rsp_fire_c && owner_ls;
         if (rsp_fire_c && !owner_ls) if_rsp_data <= mem_rsp_data;
         if (rsp_fire_c && owner_ls)  ls_rsp_data <= mem_req_we ? '0 : mem_rsp_data;

         if (mem_rsp_valid && (state != ST_WAIT_RSP)) spurious_rsp <= 1'b1;

         // Streak only counts LS wins that actually kept IF waiting
         if (!if_req_valid || grant_if_c)                  ls_streak <= '0;
         else if (grant_ls_c && (ls_streak != STREAK_MAX)) ls_streak <= ls_streak + STREAK_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a simple memory responder,
// and monitors that pop expected responses and grants as the DUT produces them.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid;
   logic [63:0] if_req_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [63:0] if_rsp_data;
   logic        ls_req_valid;
   logic        ls_req_we;
   logic [63:0] ls_req_addr;
   logic [63:0] ls_req_wdata;
   logic [7:0]  ls_req_wmask;
   logic        ls_req_ready;
   logic        ls_rsp_valid;
   logic [63:0] ls_rsp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;
   logic        busy;
   logic        spurious_rsp;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [63:0] if_exp[$];
   logic [63:0] ls_exp[$];
   int          grant_exp[$];
   bit          grant_chk = 1'b0;
   bit          auto_mem = 1'b1;
   int          inject_req = 0;
   int          inject_done = 0;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LS_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
      .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
      .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .busy(busy), .spurious_rsp(spurious_rsp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Load data the memory model returns; stores get all-ones so a missing zeroing shows up
   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      logic [31:0] lo;
      lo = a[31:0];
      if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0000_0413;
      return {lo, ~lo};
   endfunction

   // Memory responder: answers one cycle after the request handshake, or injects a stray pulse
   initial begin : responder
      logic [63:0] a;
      logic        w;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (inject_req != inject_done) begin
            inject_done++;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 64'h0000_0000_0000_1234;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
         end else if (auto_mem && mem_req_valid && mem_req_ready) begin
            a = mem_req_addr;
            w = mem_req_we;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = w ? 64'hFFFF_FFFF_FFFF_FFFF : mem_rd(a);
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
         end
      end
   end

   // Response monitor
   always @(negedge clk) begin
      if (!rst && if_rsp_valid) begin
         if (if_exp.size() == 0) check("if_rsp_unexpected", 64'd1, 64'd0);
         else                    check("if_rsp_data", if_rsp_data, if_exp.pop_front());
      end
      if (!rst && ls_rsp_valid) begin
         if (ls_exp.size() == 0) check("ls_rsp_unexpected", 64'd1, 64'd0);
         else                    check("ls_rsp_data", ls_rsp_data, ls_exp.pop_front());
      end
   end

   // Grant monitor: order check when enabled, mutual exclusion always
   always @(negedge clk) begin
      if (if_req_ready || ls_req_ready) begin
         check("ready_exclusive", 64'(if_req_ready && ls_req_ready), 64'd0);
         if (grant_chk) begin
            if (grant_exp.size() == 0) check("grant_unexpected", 64'd1, 64'd0);
            else check("grant_order", 64'(ls_req_ready), 64'(grant_exp.pop_front()));
         end
      end
   end

   task automatic if_read(input logic [63:0] addr, input bit push);
      bit ok = 1'b0;
      if_req_addr  = addr;
      if_req_valid = 1'b1;
      if (push) if_exp.push_back(mem_rd(addr));
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (if_req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("if_req_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      if_req_valid = 1'b0;
   endtask

   task automatic ls_access(input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] wmask);
      bit ok = 1'b0;
      ls_req_we    = we;
      ls_req_addr  = addr;
      ls_req_wdata = wdata;
      ls_req_wmask = wmask;
      ls_req_valid = 1'b1;
      ls_exp.push_back(we ? 64'd0 : mem_rd(addr));
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (ls_req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("ls_req_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      ls_req_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : main
      rst = 1'b1;
      if_req_valid = 1'b0; if_req_addr = '0;
      ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0;
      mem_req_ready = 1'b1;

      // 1: reset held two cycles under random inputs
      repeat (2) begin
         @(posedge clk); #1;
         if_req_valid  = 1'($urandom);
         if_req_addr   = {$urandom, $urandom};
         ls_req_valid  = 1'($urandom);
         ls_req_we     = 1'($urandom);
         ls_req_addr   = {$urandom, $urandom};
         ls_req_wdata  = {$urandom, $urandom};
         ls_req_wmask  = 8'($urandom);
         mem_req_ready = 1'($urandom);
         @(negedge clk);
         check("rst_readies", 64'({if_req_ready, ls_req_ready}), 64'd0);
         check("rst_rsp", 64'({if_rsp_valid, ls_rsp_valid, mem_req_valid, mem_req_we, busy, spurious_rsp}), 64'd0);
         check("rst_fields", mem_req_addr | mem_req_wdata | 64'(mem_req_wmask) | if_rsp_data | ls_rsp_data, 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_req_ready = 1'b1;
      idle_cycles(2);

      // 2: single IF read with latency checks
      if_read(64'h0000_0000_8000_0000, 1'b1);
      @(negedge clk);
      check("t2_cyc1_req", 64'({mem_req_valid, mem_req_we, busy}), 64'b101);
      check("t2_cyc1_addr", mem_req_addr, 64'h0000_0000_8000_0000);
      @(negedge clk);
      check("t2_cyc2_req_drop", 64'(mem_req_valid), 64'd0);
      @(negedge clk);
      check("t2_cyc3_rsp", 64'({if_rsp_valid, ls_rsp_valid, busy}), 64'b100);
      idle_cycles(2);

      // 3a: simultaneous IF and LS -> LS first, then IF
      grant_chk = 1'b1;
      grant_exp.push_back(1); grant_exp.push_back(0);
      fork
         if_read(64'h0000_0000_8000_0010, 1'b1);
         ls_access(1'b0, 64'h0000_0000_8000_1000, '0, '0);
      join
      idle_cycles(8);

      // 3b: LS continuously valid -> LS x4, IF, then LS
      for (int i = 0; i < 7; i++) grant_exp.push_back((i == 4) ? 0 : 1);
      fork
         if_read(64'h0000_0000_8000_0004, 1'b1);
         for (int i = 0; i < 6; i++) ls_access(1'b0, 64'h0000_0000_8000_2000 + 64'(8 * i), '0, '0);
      join
      idle_cycles(8);
      check("t3_grants_consumed", 64'(grant_exp.size()), 64'd0);
      grant_chk = 1'b0;

      // 4: store with memory back-pressure for three cycles
      mem_req_ready = 1'b0;
      ls_access(1'b1, 64'h0000_0000_8000_1008, 64'h0000_0000_DEAD_BEEF, 8'h0F);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) mem_req_ready = 1'b1;
         @(negedge clk);
         check("t4_req_valid_we", 64'({mem_req_valid, mem_req_we}), 64'b11);
         check("t4_addr", mem_req_addr, 64'h0000_0000_8000_1008);
         check("t4_wdata_wmask", mem_req_wdata ^ {56'd0, mem_req_wmask}, 64'h0000_0000_DEAD_BEE0);
         @(posedge clk); #1;
      end
      idle_cycles(4);

      // 5: stray response in IDLE
      check("t5_spurious_before", 64'(spurious_rsp), 64'd0);
      inject_req++;
      idle_cycles(3);
      @(negedge clk);
      check("t5_state_idle", 64'({busy, mem_req_valid}), 64'd0);
      check("t5_spurious_set", 64'(spurious_rsp), 64'd1);
      idle_cycles(5);
      @(negedge clk);
      check("t5_spurious_sticky", 64'(spurious_rsp), 64'd1);
      @(posedge clk); #1;

      // 6: reset while waiting for the response, then a late response
      auto_mem = 1'b0;
      if_read(64'h0000_0000_8000_0020, 1'b0);
      @(posedge clk); #1;
      check("t6_busy_wait", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_idle_after_rst", 64'({busy, mem_req_valid, spurious_rsp}), 64'd0);
      @(posedge clk); #1;
      inject_req++;
      idle_cycles(4);
      @(negedge clk);
      check("t6_spurious_set", 64'(spurious_rsp), 64'd1);
      check("t6_idle", 64'(busy), 64'd0);
      auto_mem = 1'b1;

      // Drain: every queued expectation must have been consumed
      for (int i = 0; i < 20 && (if_exp.size() != 0 || ls_exp.size() != 0); i++) @(posedge clk);
      check("if_exp_drained", 64'(if_exp.size()), 64'd0);
      check("ls_exp_drained", 64'(ls_exp.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
